// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
package fetch_pkg;

    // RISC-V canonical NOP (addi x0, x0, 0), shown whenever the buffer is empty.
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // ISSUE: may send a request; WAIT: one request outstanding;
    // DROP: one request outstanding whose response belongs to a stale path.
    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry output buffer holding the instruction handed to the F/D register.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic        consume,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        valid
);

    logic [31:0] instr_q;

    // Clear (redirect) beats load, load beats consume; PC is kept when emptied.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= 1'b0;
            instr_q <= NOP_INSTR;
            pc      <= 32'h0000_0000;
        end else if (clear) begin
            valid   <= 1'b0;
        end else if (load) begin
            valid   <= 1'b1;
            instr_q <= load_instr;
            pc      <= load_pc;
        end else if (consume) begin
            valid   <= 1'b0;
        end
    end

    assign instr = valid ? instr_q : NOP_INSTR;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding request FSM, PC registers and output buffer.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        ValidF
);

    fetch_state_e state, state_next;
    logic [31:0]  fetch_pc, fetch_pc_next;
    logic [31:0]  req_pc, req_pc_next;
    logic [31:0]  redirect_pc;
    logic         consume;
    logic         buf_load;

    // Redirect targets are forced to word alignment.
    assign redirect_pc = PCTargetE & ~32'd3;
    assign consume     = ValidF && !StallF;

    // A new request is only sent when its response is sure to find the buffer empty.
    assign imem_req  = !rst && (state == ISSUE) && !PCSrcE && (!ValidF || consume);
    assign imem_addr = fetch_pc;
    assign PCPlus4F  = PCF + 32'd4;

    // State and PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ISSUE;
            fetch_pc <= RESET_PC;
            req_pc   <= 32'h0000_0000;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            req_pc   <= req_pc_next;
        end
    end

    // Next-state logic; a redirect always wins over the normal request/response flow.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        req_pc_next   = req_pc;
        buf_load      = 1'b0;
        case (state)
            ISSUE: begin
                if (PCSrcE) begin
                    fetch_pc_next = redirect_pc;
                end else if (imem_req && imem_gnt) begin
                    req_pc_next   = fetch_pc;
                    fetch_pc_next = fetch_pc + 32'd4;
                    state_next    = WAIT;
                end
            end
            WAIT: begin
                if (PCSrcE) begin
                    fetch_pc_next = redirect_pc;
                    // A response arriving with the redirect is simply discarded.
                    state_next    = imem_rvalid ? ISSUE : DROP;
                end else if (imem_rvalid) begin
                    buf_load   = 1'b1;
                    state_next = ISSUE;
                end
            end
            DROP: begin
                if (PCSrcE) begin
                    fetch_pc_next = redirect_pc;
                end
                if (imem_rvalid) begin
                    state_next = ISSUE;
                end
            end
            default: begin
                state_next = ISSUE;
            end
        endcase
    end

    fetch_buffer u_buffer (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .clear      (PCSrcE),
        .consume    (consume),
        .load_instr (imem_rdata),
        .load_pc    (req_pc),
        .instr      (InstrF),
        .pc         (PCF),
        .valid      (ValidF)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios, then randomized traffic
// checked against an instruction-stream reference model.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        StallF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        ValidF;

    int compared = 0;
    int mismatched = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .StallF      (StallF),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .InstrF      (InstrF),
        .PCF         (PCF),
        .PCPlus4F    (PCPlus4F),
        .ValidF      (ValidF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory contents as a function of address for the randomized phase.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5EED_C0DE;
    endfunction

    // Memory model state (one pending response) and instruction-stream model.
    logic        pend_valid;
    logic [31:0] pend_addr;
    int          pend_wait;
    logic [31:0] exp_pc;
    int          delivered;
    int          idle;
    logic        granted;

    initial begin
        rst = 1'b1; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        tick();
        // Reset cycle
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, ValidF}, 32'd0);
        chk("rst_instr", InstrF, NOP);
        chk("rst_pcf", PCF, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        tick();

        // First fetch: grant then 1-cycle response
        rst = 1'b0; imem_gnt = 1'b1; #1;
        chk("f1_req", {31'd0, imem_req}, 32'd1);
        chk("f1_addr", imem_addr, 32'h0);
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_0001; #1;
        chk("f1_wait_req", {31'd0, imem_req}, 32'd0);
        chk("f1_wait_addr", imem_addr, 32'h4);
        tick();

        // Stall for 5 cycles with a valid entry
        imem_rvalid = 1'b0; imem_rdata = '0; StallF = 1'b1; imem_gnt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_valid", {31'd0, ValidF}, 32'd1);
            chk("stall_pcf", PCF, 32'h0);
            chk("stall_instr", InstrF, 32'hAAAA_0001);
            chk("stall_pc4", PCPlus4F, 32'h4);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
            tick();
        end
        // Release: consume and request on the same edge
        StallF = 1'b0; #1;
        chk("rel_req", {31'd0, imem_req}, 32'd1);
        chk("rel_addr", imem_addr, 32'h4);
        tick();
        imem_gnt = 1'b0; #1;
        chk("rel_empty", {31'd0, ValidF}, 32'd0);
        chk("rel_nop", InstrF, NOP);
        chk("rel_pcf_hold", PCF, 32'h0);

        // Redirect while waiting; response arrives a cycle later and is dropped
        PCSrcE = 1'b1; PCTargetE = 32'h0000_0103; #1;
        chk("redir_req", {31'd0, imem_req}, 32'd0);
        tick();
        PCSrcE = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
        chk("drop_req", {31'd0, imem_req}, 32'd0);
        chk("drop_addr", imem_addr, 32'h100);
        tick();
        imem_rvalid = 1'b0; imem_gnt = 1'b1; #1;
        chk("drop_valid", {31'd0, ValidF}, 32'd0);
        chk("drop_instr", InstrF, NOP);
        chk("after_drop_req", {31'd0, imem_req}, 32'd1);
        chk("after_drop_addr", imem_addr, 32'h100);
        tick();

        // Redirect coincident with the response
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0001;
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC; #1;
        tick();
        PCSrcE = 1'b0; imem_rvalid = 1'b0; imem_gnt = 1'b1; #1;
        chk("coin_valid", {31'd0, ValidF}, 32'd0);
        chk("coin_req", {31'd0, imem_req}, 32'd1);
        chk("coin_addr", imem_addr, 32'hFFFF_FFFC);
        tick();

        // Wrap at the top of the address space
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678; #1;
        chk("wrap_addr", imem_addr, 32'h0);
        tick();
        imem_rvalid = 1'b0; StallF = 1'b1; #1;
        chk("wrap_valid", {31'd0, ValidF}, 32'd1);
        chk("wrap_pcf", PCF, 32'hFFFF_FFFC);
        chk("wrap_pc4", PCPlus4F, 32'h0);
        chk("wrap_instr", InstrF, 32'h1234_5678);
        tick();
        StallF = 1'b0; imem_gnt = 1'b1; #1;
        chk("wrap2_req", {31'd0, imem_req}, 32'd1);
        chk("wrap2_addr", imem_addr, 32'h0);
        tick();

        // Reset while waiting; the late response must be ignored
        imem_gnt = 1'b0; rst = 1'b1; #1;
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        tick();
        rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_0BAD; #1;
        chk("late_req", {31'd0, imem_req}, 32'd1);
        chk("late_addr", imem_addr, 32'h0);
        tick();
        imem_rvalid = 1'b0; imem_rdata = '0; #1;
        chk("late_valid", {31'd0, ValidF}, 32'd0);
        chk("late_instr", InstrF, NOP);
        chk("late_addr2", imem_addr, 32'h0);

        // Randomized traffic: the delivered stream must be sequential from the
        // last redirect target, with the memory contents at each PC.
        pend_valid = 1'b0; pend_addr = '0; pend_wait = 0;
        exp_pc = 32'h0; delivered = 0; idle = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            StallF = ($urandom_range(0, 3) == 0);
            PCSrcE = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0)
                PCTargetE = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else
                PCTargetE = 32'($urandom_range(0, 1023));
            imem_rvalid = pend_valid && (pend_wait == 0);
            imem_rdata  = imem_rvalid ? mem_word(pend_addr) : 32'($urandom);
            #1;
            imem_gnt = imem_req ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 1) == 1);
            #1;
            granted = imem_req && imem_gnt;
            if (ValidF && !StallF && !PCSrcE) begin
                chk("rnd_pcf", PCF, exp_pc);
                chk("rnd_instr", InstrF, mem_word(exp_pc));
                chk("rnd_pc4", PCPlus4F, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                delivered++;
                idle = 0;
            end else begin
                idle++;
            end
            if (granted)
                chk("rnd_one_outstanding", {31'd0, pend_valid}, 32'd0);
            if (PCSrcE) begin
                exp_pc = PCTargetE & ~32'd3;
                idle = 0;
            end
            if (idle == 60)
                chk("rnd_progress", 32'(idle), 32'd0);
            if (imem_rvalid)
                pend_valid = 1'b0;
            if (granted) begin
                pend_valid = 1'b1;
                pend_addr  = imem_addr;
                pend_wait  = $urandom_range(0, 2);
            end else if (pend_valid && !imem_rvalid) begin
                pend_wait--;
            end
            tick();
        end
        chk("rnd_delivered_enough", {31'd0, delivered >= 250}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port StallF, input, 1 bit: the F/D register is not accepting this cycle.
REQ-005 The module SHALL have port PCSrcE, input, 1 bit: redirect request from the execute stage (taken branch, jal or jalr).
REQ-006 The module SHALL have port PCTargetE, input, 32 bits: redirect address.
REQ-007 The module SHALL have port imem_req, output, 1 bit: instruction-memory request valid.
REQ-008 The module SHALL have port imem_addr, output, 32 bits: request address.
REQ-009 The module SHALL have port imem_gnt, input, 1 bit: request accepted this cycle.
REQ-010 The module SHALL have port imem_rvalid, input, 1 bit: response valid, arriving at least 1 cycle after the grant.
REQ-011 The module SHALL have port imem_rdata, input, 32 bits: response instruction word.
REQ-012 The module SHALL have port InstrF, output, 32 bits: instruction to the F/D register.
REQ-013 The module SHALL have port PCF, output, 32 bits: PC of InstrF.
REQ-014 The module SHALL have port PCPlus4F, output, 32 bits: PCF+4.
REQ-015 The module SHALL have port ValidF, output, 1 bit: InstrF/PCF hold a real instruction.

Function
REQ-016 The module SHALL keep a fetch PC register, a request-PC register, a 1-entry output buffer {InstrF, PCF, ValidF} and an FSM with states ISSUE, WAIT and DROP.
REQ-017 The module SHALL define consume = ValidF && !StallF; a consumed buffer entry leaves the buffer on that edge.
REQ-018 The module SHALL drive imem_req = (state==ISSUE) && !PCSrcE && (!ValidF || consume), with imem_addr = fetch PC at all times.
REQ-019 ISSUE with imem_req && imem_gnt SHALL latch request-PC <= fetch PC, set fetch PC <= fetch PC+4 (mod 2^32) and move to WAIT; without a grant it SHALL stay in ISSUE with request and address held.
REQ-020 WAIT with imem_rvalid and no PCSrcE SHALL load the buffer with {imem_rdata, request-PC, 1}, and the FSM SHALL return to ISSUE.
REQ-021 The module SHALL allow only one outstanding request; the buffer is therefore always empty when a response arrives, and overflow is impossible.
REQ-022 PCSrcE SHALL have the highest priority in every state: fetch PC <= {PCTargetE[31:2], 2'b00} and ValidF <= 0; in ISSUE no request is issued that cycle.
REQ-023 PCSrcE in WAIT SHALL take the FSM to DROP if imem_rvalid is low that cycle, or to ISSUE with the response discarded if imem_rvalid is high.
REQ-024 DROP SHALL discard the next imem_rvalid response without touching the buffer and then move to ISSUE; PCSrcE in DROP only updates the fetch PC.
REQ-025 imem_rvalid in ISSUE SHALL be ignored.
REQ-026 When ValidF=0, InstrF SHALL read 32'h0000_0013 (NOP) and PCF SHALL hold its last value.
REQ-027 PCPlus4F SHALL be the combinational PCF+4, wrapping mod 2^32.
REQ-028 Peak throughput SHALL be one instruction per 2 cycles with a 1-cycle grant and 1-cycle response.
REQ-029 While StallF is held, the buffer contents SHALL be unchanged.

Reset
REQ-030 rst SHALL set: state=ISSUE, fetch PC=RESET_PC, request-PC=0, ValidF=0, InstrF=NOP, PCF=0.
REQ-031 imem_req SHALL be 0 during the reset cycle.
REQ-032 A reset mid-transaction SHALL abandon the outstanding request, and its late response SHALL be ignored per REQ-025.

Structure
REQ-033 Package fetch_pkg SHALL hold the NOP constant 32'h0000_0013, the FSM state enum and the RESET_PC default.
REQ-034 The output buffer SHALL be a sub-module fetch_buffer with load, clear and consume controls.
REQ-035 The FSM and the PC registers SHALL stay in fetch_unit.

Verification
REQ-036 Reset, then gnt=1 and 1-cycle rvalid returning 0xAAAA0001 -> imem_addr 0x0, then 0x4; ValidF=1 with PCF=0x0, InstrF=0xAAAA0001, PCPlus4F=0x4 two cycles after the grant.
REQ-037 StallF held high for 5 cycles with ValidF=1 -> buffer unchanged and imem_req=0 throughout; after release, the next request goes to 0x4 on the same edge the entry is consumed.
REQ-038 PCSrcE=1 with PCTargetE=0x103 while in WAIT, and rvalid one cycle later -> response dropped, ValidF=0, next imem_addr=0x100, and no instruction from the old path appears.
REQ-039 PCSrcE=1 in the same cycle as rvalid -> response discarded, FSM in ISSUE next cycle, and imem_addr equals the target.
REQ-040 Fetch PC 0xFFFF_FFFC granted -> next imem_addr 0x0000_0000, and PCPlus4F for that instruction = 0x0.
REQ-041 rst asserted in WAIT, then rvalid arrives -> ignored, ValidF=0, and first request to RESET_PC.
